// File: rtl/gate_chk_pkg.sv
// Shared types and the gate truth-table helper for the gate response checker.
//   gate_op_e : gate selector carried on gate_sel and latched at run start
//   state_e   : checker run state (idle, running, one-cycle done)
//   gate_eval : single-bit expected output of the selected gate; callers apply it
//               bit by bit to build a WIDTH-wide bitwise result
package gate_chk_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_BUFA = 3'd6,
        OP_NOTA = 3'd7
    } gate_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Expected single-bit output of the gate selected by op for inputs a, b.
    function automatic logic gate_eval(input gate_op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_BUFA: r = a;
            OP_NOTA: r = ~a;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_chk_delay.sv
// Valid + data alignment line for the gate response checker.
// Delays {in_valid, in_data} by DEPTH clock cycles so the expected value meets
// the DUT output of the same vector. DEPTH = 0 is a plain wire.
//   clk       in   1      clock, rising edge
//   rst_n     in   1      asynchronous reset, active-low (clears all stages)
//   in_valid  in   1      vector accepted this cycle
//   in_data   in   W      expected result of that vector
//   out_valid out  1      delayed valid
//   out_data  out  W      delayed expected result
module gate_chk_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock and reset have no job in the combinational case.
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ rst_n;
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld_r;
            logic [W-1:0]     dat_r [DEPTH];

            // Shift valid and data one stage per clock; reset empties the line.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_r <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        dat_r[i] <= '0;
                    end
                end else begin
                    vld_r[0] <= in_valid;
                    dat_r[0] <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_r[i] <= vld_r[i-1];
                        dat_r[i] <= dat_r[i-1];
                    end
                end
            end

            assign out_valid = vld_r[DEPTH-1];
            assign out_data  = dat_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/gate_resp_checker.sv
// Checker end of the basic-gate test flow. Receives the operand vectors that
// the driver applies to a gate under test plus the gate output, computes the
// expected result, aligns it to the DUT latency, compares and keeps statistics.
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           begin a run; honoured only in IDLE
//   gate_sel        gate_op_e, latched on an accepted start
//   vec_valid       vec_a/vec_b valid this cycle
//   vec_a, vec_b    operands as driven to the DUT
//   dut_y           DUT output
//   busy            high while a run is in progress
//   done            one-cycle pulse at end of run
//   pass            run finished with zero mismatches; held until next start
//   vec_cnt         vectors compared this run
//   err_cnt         mismatches this run, saturating
//   first_err_idx   vec_cnt value at the first mismatch
//   first_err_exp   expected y at the first mismatch
//   first_err_got   dut_y at the first mismatch
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 0,
    parameter int N_VECS  = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       gate_sel,
    input  logic             vec_valid,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got
);

    localparam logic [CNT_W-1:0] N_VECS_C = CNT_W'(N_VECS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_r;
    state_e           state_nxt_s;
    gate_op_e         op_r;
    logic [CNT_W-1:0] acc_cnt_r;
    logic [CNT_W-1:0] vec_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] first_err_idx_r;
    logic [WIDTH-1:0] first_err_exp_r;
    logic [WIDTH-1:0] first_err_got_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    logic [WIDTH-1:0] exp_s;
    logic [WIDTH-1:0] dly_exp_s;
    logic             dly_valid_s;
    logic             start_ok_s;
    logic             accept_s;
    logic             compare_s;
    logic             mismatch_s;
    logic             last_cmp_s;

    // Expected DUT output for the current operands under the latched gate.
    always_comb begin
        exp_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            exp_s[i] = gate_eval(op_r, vec_a[i], vec_b[i]);
        end
    end

    // Acceptance and compare qualifiers. The accept limit stops extra vectors
    // while earlier ones are still draining through the delay line.
    always_comb begin
        start_ok_s = (state_r == S_IDLE) && start;
        accept_s   = (state_r == S_RUN) && vec_valid && (acc_cnt_r < N_VECS_C);
        compare_s  = (state_r == S_RUN) && dly_valid_s;
        // Case inequality so that an X on dut_y is a mismatch in simulation.
        mismatch_s = compare_s && (dut_y !== dly_exp_s);
        last_cmp_s = compare_s && ((vec_cnt_r + CNT_ONE) == N_VECS_C);
    end

    gate_chk_delay #(
        .W     (WIDTH),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept_s),
        .in_data   (exp_s),
        .out_valid (dly_valid_s),
        .out_data  (dly_exp_s)
    );

    // Run state next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_cmp_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register with registered busy/done flags that follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_RUN);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Op latch, counters, first-error capture and pass verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r            <= OP_AND;
            acc_cnt_r       <= '0;
            vec_cnt_r       <= '0;
            err_cnt_r       <= '0;
            first_err_idx_r <= '0;
            first_err_exp_r <= '0;
            first_err_got_r <= '0;
            pass_r          <= 1'b0;
        end else if (start_ok_s) begin
            op_r            <= gate_op_e'(gate_sel);
            acc_cnt_r       <= '0;
            vec_cnt_r       <= '0;
            err_cnt_r       <= '0;
            first_err_idx_r <= '0;
            first_err_exp_r <= '0;
            first_err_got_r <= '0;
            pass_r          <= 1'b0;
        end else begin
            if (accept_s) begin
                acc_cnt_r <= acc_cnt_r + CNT_ONE;
            end
            if (compare_s) begin
                vec_cnt_r <= vec_cnt_r + CNT_ONE;
            end
            if (mismatch_s) begin
                if (err_cnt_r != CNT_MAX) begin
                    err_cnt_r <= err_cnt_r + CNT_ONE;
                end
                // Only the very first mismatch of the run is recorded.
                if (err_cnt_r == '0) begin
                    first_err_idx_r <= vec_cnt_r;
                    first_err_exp_r <= dly_exp_s;
                    first_err_got_r <= dut_y;
                end
            end
            // Verdict includes the final compare, so it is valid alongside done.
            if (last_cmp_s) begin
                pass_r <= (err_cnt_r == '0) && !mismatch_s;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign vec_cnt       = vec_cnt_r;
    assign err_cnt       = err_cnt_r;
    assign first_err_idx = first_err_idx_r;
    assign first_err_exp = first_err_exp_r;
    assign first_err_got = first_err_got_r;

endmodule
